// File: rtl/fp16_serial_normalizer_pkg.sv
// Shared widths, derived constants and FSM state encoding for the fp16 serial normaliser.
package fp16_serial_normalizer_pkg;

    localparam int MW   = 12;
    localparam int EW   = 5;
    localparam int EMAX = (1 << EW) - 1;
    localparam int SCW  = $clog2(MW);

    // Exponent constants sized to the internal EW+1-bit exponent path.
    localparam logic [EW:0] EXP_ONE = (EW+1)'(1);
    localparam logic [EW:0] EXP_INF = (EW+1)'(EMAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_serial_normalizer_shift_ctr.sv
// Shift-count stage: up-counter with synchronous clear and count enable.
module fp_shift_ctr
    import fp16_serial_normalizer_pkg::*;
#(
    parameter int W = SCW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fp16_serial_normalizer.sv
// Multi-cycle normaliser after the mantissa adder: fixes a carry with one right shift or
// left-shifts one bit per clock until the hidden bit is set. start is a request accepted only in IDLE; done pulses once per accepted request.
module fp16_serial_normalizer
    import fp16_serial_normalizer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sign_in,
    input  logic [EW-1:0] exp_in,
    input  logic [MW-1:0] man_in,
    output logic          busy,
    output logic          shift_en,
    output logic          done,
    output logic          sign_out,
    output logic [EW-1:0] exp_out,
    output logic [MW-2:0] man_out,
    output logic [SCW-1:0] shift_cnt,
    output logic          sticky,
    output logic          zero,
    output logic          underflow,
    output logic          overflow,
    output state_t        dbg_state
);

    state_t        r_state;
    logic          r_sign;
    logic [MW-1:0] r_man;
    logic [EW:0]   r_exp;

    logic          r_sign_out;
    logic [EW-1:0] r_exp_out;
    logic [MW-2:0] r_man_out;
    logic          r_sticky;
    logic          r_zero;
    logic          r_uf;
    logic          r_of;

    state_t        w_state_nxt;
    logic [MW-1:0] w_man_nxt;
    logic [EW:0]   w_exp_nxt;
    logic          w_sticky_nxt;
    logic          w_zero_nxt;
    logic          w_uf_nxt;
    logic          w_of_nxt;
    logic          w_load;
    logic          w_shift;

    logic [EW:0]   w_exp_inc;
    logic [EW:0]   w_exp_dec;
    logic [MW-1:0] w_man_shl;

    assign w_exp_inc = r_exp + EXP_ONE;
    assign w_exp_dec = r_exp - EXP_ONE;
    assign w_man_shl = {r_man[MW-2:0], 1'b0};

    always_comb begin
        w_state_nxt  = r_state;
        w_man_nxt    = r_man;
        w_exp_nxt    = r_exp;
        w_sticky_nxt = 1'b0;
        w_zero_nxt   = 1'b0;
        w_uf_nxt     = 1'b0;
        w_of_nxt     = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_man_nxt   = man_in;
                    // A zero exponent means subnormal; its effective exponent is 1.
                    w_exp_nxt   = (exp_in == '0) ? EXP_ONE : {1'b0, exp_in};
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (r_man == '0) begin
                    w_zero_nxt  = 1'b1;
                    w_exp_nxt   = '0;
                    w_state_nxt = DONE;
                end else if (r_man[MW-1]) begin
                    w_man_nxt    = r_man >> 1;
                    w_sticky_nxt = r_man[0];
                    w_exp_nxt    = w_exp_inc;
                    if (w_exp_inc >= EXP_INF) begin
                        w_of_nxt  = 1'b1;
                        w_man_nxt = '0;
                        w_exp_nxt = EXP_INF;
                    end
                    w_state_nxt = DONE;
                end else if (r_man[MW-2]) begin
                    w_state_nxt = DONE;
                end else if (r_exp == EXP_ONE) begin
                    w_uf_nxt    = 1'b1;
                    w_exp_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift   = 1'b1;
                w_man_nxt = w_man_shl;
                w_exp_nxt = w_exp_dec;
                // Hidden bit wins over underflow when both happen on the same shift.
                if (w_man_shl[MW-2]) begin
                    w_state_nxt = DONE;
                end else if (w_exp_dec == EXP_ONE) begin
                    w_uf_nxt    = 1'b1;
                    w_exp_nxt   = '0;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_man      <= '0;
            r_exp      <= '0;
            r_sign_out <= 1'b0;
            r_exp_out  <= '0;
            r_man_out  <= '0;
            r_sticky   <= 1'b0;
            r_zero     <= 1'b0;
            r_uf       <= 1'b0;
            r_of       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_man   <= w_man_nxt;
            r_exp   <= w_exp_nxt;
            if (w_load) begin
                r_sign <= sign_in;
            end
            // Results are published only on entry to DONE and then held.
            if (w_state_nxt == DONE) begin
                r_sign_out <= r_sign;
                r_exp_out  <= w_exp_nxt[EW-1:0];
                r_man_out  <= w_man_nxt[MW-2:0];
                r_sticky   <= w_sticky_nxt;
                r_zero     <= w_zero_nxt;
                r_uf       <= w_uf_nxt;
                r_of       <= w_of_nxt;
            end
        end
    end

    fp_shift_ctr #(
        .W (SCW)
    ) u_shift_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_load),
        .i_en  (w_shift),
        .o_cnt (shift_cnt)
    );

    assign busy      = (r_state == CHECK) || (r_state == SHIFT);
    assign shift_en  = (r_state == SHIFT);
    assign done      = (r_state == DONE);
    assign sign_out  = r_sign_out;
    assign exp_out   = r_exp_out;
    assign man_out   = r_man_out;
    assign sticky    = r_sticky;
    assign zero      = r_zero;
    assign underflow = r_uf;
    assign overflow  = r_of;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fp16_serial_normalizer.sv
// Self-checking bench for fp16_serial_normalizer: directed cases, randomized cases against a
// behavioural model, busy-ignore, back-to-back, output hold and mid-operation reset.
module tb_fp16_serial_normalizer;
    import fp16_serial_normalizer_pkg::*;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [10:0] man;
        logic [3:0] cnt;
        logic       sticky;
        logic       zero;
        logic       uf;
        logic       of;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          sign_in = 1'b0;
    logic [EW-1:0] exp_in = '0;
    logic [MW-1:0] man_in = '0;
    logic          busy, shift_en, done, sign_out, sticky, zero, underflow, overflow;
    logic [EW-1:0] exp_out;
    logic [MW-2:0] man_out;
    logic [SCW-1:0] shift_cnt;
    state_t        dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int n_chk = 0;

    fp16_serial_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .man_in    (man_in),
        .busy      (busy),
        .shift_en  (shift_en),
        .done      (done),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .man_out   (man_out),
        .shift_cnt (shift_cnt),
        .sticky    (sticky),
        .zero      (zero),
        .underflow (underflow),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural model: normalise with plain integer arithmetic.
    function automatic res_t ref_model(input logic s, input logic [4:0] e_in, input logic [11:0] m_in);
        res_t r;
        int e;
        int m;
        int n;
        r = '0;
        r.sign = s;
        e = (e_in == 0) ? 1 : int'(e_in);
        m = int'(m_in);
        n = 0;
        if (m == 0) begin
            r.zero = 1'b1;
            e = 0;
        end else if (m >= 2048) begin
            r.sticky = (m % 2 == 1);
            m = m / 2;
            e = e + 1;
            if (e >= 31) begin
                r.of = 1'b1;
                m = 0;
                e = 31;
            end
        end else if (m < 1024) begin
            while (m < 1024 && e > 1) begin
                m = m * 2;
                e = e - 1;
                n = n + 1;
            end
            if (m < 1024) begin
                r.uf = 1'b1;
                e = 0;
            end
        end
        r.exp = 5'(e);
        r.man = 11'(m);
        r.cnt = 4'(n);
        return r;
    endfunction

    function automatic res_t observed();
        return {sign_out, exp_out, man_out, shift_cnt, sticky, zero, underflow, overflow};
    endfunction

    // Latency is counted in cycles after the start-sampling edge; cycle 1 is the one right after it.
    task automatic drive_op(input logic s, input logic [4:0] e, input logic [11:0] m,
                            output res_t obs, output int lat, output int sen, output bit to);
        @(negedge clk);
        sign_in = s;
        exp_in  = e;
        man_in  = m;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        sign_in = 1'($urandom);
        exp_in  = 5'($urandom);
        man_in  = 12'($urandom);
        lat = 0;
        sen = 0;
        to  = 1'b1;
        obs = '0;
        n_vec++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (shift_en) sen++;
            if (done) begin
                lat = c;
                to  = 1'b0;
                obs = observed();
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if ({busy, shift_en, done, sign_out, exp_out, man_out, shift_cnt, sticky, zero, underflow, overflow} !== '0) begin
            $display("FAIL reset_outputs got=%h want=0",
                     {busy, shift_en, done, sign_out, exp_out, man_out, shift_cnt, sticky, zero, underflow, overflow});
            n_err++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done);
            n_err++;
        end
    endtask

    task automatic test_directed();
        int   te[12] = '{15, 15, 15, 3, 30, 7, 0, 0, 1, 12, 11, 30};
        int   tm[12] = '{'h400, 'h801, 'h008, 'h010, 'hC00, 'h000, 'h400, 'h200, 'h001, 'h001, 'h001, 'h800};
        int   we[12] = '{15, 16, 8, 0, 31, 0, 1, 0, 0, 2, 1, 31};
        int   wm[12] = '{'h400, 'h400, 'h400, 'h040, 0, 0, 'h400, 'h200, 'h001, 'h400, 'h400, 0};
        int   wn[12] = '{0, 0, 7, 2, 0, 0, 0, 0, 0, 10, 10, 0};
        int   wf[12] = '{0, 8, 0, 2, 1, 4, 0, 2, 2, 0, 0, 1};
        res_t want;
        res_t obs;
        int   lat;
        int   sen;
        bit   to;
        for (int i = 0; i < 12; i++) begin
            want = {1'(i % 2), 5'(we[i]), 11'(wm[i]), 4'(wn[i]), 4'(wf[i])};
            drive_op(1'(i % 2), 5'(te[i]), 12'(tm[i]), obs, lat, sen, to);
            n_chk++;
            if (to) begin
                $display("FAIL directed_timeout case=%0d got=no done want=done", i);
                n_err++;
            end else begin
                n_chk += 3;
                if (lat !== wn[i] + 2) begin
                    $display("FAIL directed_latency case=%0d got=%0d want=%0d", i, lat, wn[i] + 2);
                    n_err++;
                end
                if (sen !== wn[i]) begin
                    $display("FAIL directed_shift_en case=%0d got=%0d want=%0d", i, sen, wn[i]);
                    n_err++;
                end
                if (obs !== want) begin
                    $display("FAIL directed_result case=%0d got=%h want=%h", i, obs, want);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_random();
        res_t want;
        res_t obs;
        int   lat;
        int   sen;
        bit   to;
        int   m;
        int   p;
        logic s;
        logic [4:0] e;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: m = 0;
                1: m = $urandom_range(0, 4095);
                2: begin
                    p = $urandom_range(0, 10);
                    m = (1 << p) | ($urandom_range(0, 4095) & ((1 << p) - 1));
                end
                default: m = 2048 | $urandom_range(0, 2047);
            endcase
            e = 5'($urandom_range(0, 30));
            s = 1'($urandom);
            want = ref_model(s, e, 12'(m));
            drive_op(s, e, 12'(m), obs, lat, sen, to);
            n_chk++;
            if (to) begin
                $display("FAIL random_timeout exp_in=%0d man_in=%h got=no done want=done", e, m);
                n_err++;
            end else begin
                n_chk += 3;
                if (lat !== int'(want.cnt) + 2) begin
                    $display("FAIL random_latency exp_in=%0d man_in=%h got=%0d want=%0d", e, m, lat, int'(want.cnt) + 2);
                    n_err++;
                end
                if (sen !== int'(want.cnt)) begin
                    $display("FAIL random_shift_en exp_in=%0d man_in=%h got=%0d want=%0d", e, m, sen, want.cnt);
                    n_err++;
                end
                if (obs !== want) begin
                    $display("FAIL random_result exp_in=%0d man_in=%h got=%h want=%h", e, m, obs, want);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        res_t want;
        int   lat;
        bit   seen;
        want = ref_model(1'b0, 5'd15, 12'h008);
        @(negedge clk);
        sign_in = 1'b0;
        exp_in  = 5'd15;
        man_in  = 12'h008;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_vec++;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 3) begin
                sign_in = 1'b1;
                exp_in  = 5'd30;
                man_in  = 12'hC00;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        n_chk += 2;
        if (!seen || lat !== 9) begin
            $display("FAIL busy_ignore_latency got=%0d want=9", lat);
            n_err++;
        end
        if (observed() !== want) begin
            $display("FAIL busy_ignore_result got=%h want=%h", observed(), want);
            n_err++;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                $display("FAIL busy_ignore_not_queued cycle=%0d busy=%b done=%b want 0 0", c, busy, done);
                n_err++;
            end
        end
    endtask

    task automatic test_hold();
        res_t obs;
        int   lat;
        int   sen;
        bit   to;
        drive_op(1'b1, 5'd15, 12'h801, obs, lat, sen, to);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk += 2;
            if (done !== 1'b0) begin
                $display("FAIL hold_done_pulse cycle=%0d got=%b want=0", c, done);
                n_err++;
            end
            if (to || observed() !== ref_model(1'b1, 5'd15, 12'h801)) begin
                $display("FAIL hold_results cycle=%0d got=%h want=%h", c, observed(), ref_model(1'b1, 5'd15, 12'h801));
                n_err++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] bm[4] = '{12'h001, 12'hFFF, 12'h000, 12'h0F0};
        logic [4:0]  be[4] = '{5'd20, 5'd29, 5'd9, 5'd4};
        res_t want;
        res_t obs;
        int   lat;
        int   sen;
        bit   to;
        for (int i = 0; i < 4; i++) begin
            want = ref_model(1'(i), be[i], bm[i]);
            drive_op(1'(i), be[i], bm[i], obs, lat, sen, to);
            n_chk += 2;
            if (to || lat !== int'(want.cnt) + 2) begin
                $display("FAIL b2b_latency case=%0d got=%0d want=%0d", i, lat, int'(want.cnt) + 2);
                n_err++;
            end
            if (obs !== want) begin
                $display("FAIL b2b_result case=%0d got=%h want=%h", i, obs, want);
                n_err++;
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        res_t obs;
        int   lat;
        int   sen;
        bit   to;
        bit   seen;
        @(negedge clk);
        sign_in = 1'b1;
        exp_in  = 5'd20;
        man_in  = 12'h001;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_vec++;
        repeat (4) @(negedge clk);
        n_chk++;
        if (shift_en !== 1'b1) begin
            $display("FAIL reset_mid_precondition shift_en got=%b want=1", shift_en);
            n_err++;
        end
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({busy, shift_en, done, sign_out, exp_out, man_out, shift_cnt, sticky, zero, underflow, overflow} !== '0) begin
            $display("FAIL reset_mid_outputs got=%h want=0",
                     {busy, shift_en, done, sign_out, exp_out, man_out, shift_cnt, sticky, zero, underflow, overflow});
            n_err++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin
            $display("FAIL reset_mid_no_done got=activity want=idle");
            n_err++;
        end
        drive_op(1'b0, 5'd15, 12'h008, obs, lat, sen, to);
        n_chk++;
        if (to || obs !== ref_model(1'b0, 5'd15, 12'h008)) begin
            $display("FAIL reset_mid_recovery got=%h want=%h", obs, ref_model(1'b0, 5'd15, 12'h008));
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_hold();
        test_back_to_back();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
